// File: rtl/rv16_mul_issue.sv
// rv16_mul_issue: issue stage for an external 32x32 multiplier.
// Requests are queued in a small FIFO and issued one at a time. The result
// is held on the writeback port until it is accepted. A flush pulse empties
// the queue and drains any multiply already in flight without a writeback.
//
// Handshakes: a transfer happens on the rising edge where valid && ready are
// both high. A producer holds valid and payload stable until that edge.
// req_ready may be read combinationally. wb_valid/wb_rd/wb_data are registered
// and are held until wb_ready is seen.
module rv16_mul_issue #(
    parameter int QDEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [4:0]                    req_rd,
    input  logic [31:0]                   req_a,
    input  logic [31:0]                   req_b,
    input  logic                          flush,
    output logic                          mul_start,
    output logic [31:0]                   mul_op_a,
    output logic [31:0]                   mul_op_b,
    input  logic                          mul_busy,
    input  logic                          mul_done,
    input  logic [31:0]                   mul_result,
    output logic                          wb_valid,
    input  logic                          wb_ready,
    output logic [4:0]                    wb_rd,
    output logic [31:0]                   wb_data,
    output logic [1:0]                    fsm_state,
    output logic [$clog2(QDEPTH+1)-1:0]   occupancy
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        WB    = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t          state;
    logic [4:0]      q_rd [QDEPTH];
    logic [31:0]     q_a  [QDEPTH];
    logic [31:0]     q_b  [QDEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [4:0]      flight_rd;
    logic            push;
    logic            pop;
    logic            can_issue;

    // Space is reported only when not flushing, so a flush edge never pushes.
    assign req_ready = (count < CW'(QDEPTH)) && !flush;
    assign push      = req_valid && req_ready;

    // Issue is allowed from IDLE, or from WB in the cycle its result leaves.
    assign can_issue = (count != '0) && !mul_busy && !flush;
    assign pop       = can_issue && ((state == IDLE) || ((state == WB) && wb_ready));

    assign fsm_state = state;
    assign occupancy = count;

    // Queue payload storage, written on every accepted push.
    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[wr_ptr] <= req_rd;
            q_a[wr_ptr]  <= req_a;
            q_b[wr_ptr]  <= req_b;
        end
    end

    // Queue pointers and occupancy; flush empties the queue outright.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Issue/writeback sequencer with registered multiplier and writeback outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mul_start <= 1'b0;
            mul_op_a  <= '0;
            mul_op_b  <= '0;
            flight_rd <= '0;
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
        end else begin
            mul_start <= 1'b0;
            if (pop) begin
                mul_start <= 1'b1;
                mul_op_a  <= q_a[rd_ptr];
                mul_op_b  <= q_b[rd_ptr];
                flight_rd <= q_rd[rd_ptr];
            end
            case (state)
                IDLE: begin
                    if (pop) state <= WAIT;
                end
                WAIT: begin
                    // mul_done is ignored in the start cycle: it cannot belong to this op.
                    if (flush) begin
                        // A done arriving with the flush already retires the op.
                        state <= (mul_done && !mul_start) ? IDLE : DRAIN;
                    end else if (mul_done && !mul_start) begin
                        wb_valid <= 1'b1;
                        wb_rd    <= flight_rd;
                        wb_data  <= mul_result;
                        state    <= WB;
                    end
                end
                WB: begin
                    if (flush) begin
                        wb_valid <= 1'b0;
                        state    <= IDLE;
                    end else if (wb_ready) begin
                        wb_valid <= 1'b0;
                        state    <= pop ? WAIT : IDLE;
                    end
                end
                DRAIN: begin
                    if (mul_done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv16_mul_issue.sv
// Bench for rv16_mul_issue: directed scenarios plus a randomized run,
// with a behavioural multiplier whose done comes 4 registered stages after start.
module tb_rv16_mul_issue;

    localparam int QDEPTH = 2;
    localparam int CW = $clog2(QDEPTH + 1);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic [4:0]     req_rd = '0;
    logic [31:0]    req_a = '0;
    logic [31:0]    req_b = '0;
    logic           flush = 1'b0;
    logic           mul_start;
    logic [31:0]    mul_op_a;
    logic [31:0]    mul_op_b;
    logic           mul_busy;
    logic           mul_done;
    logic [31:0]    mul_result;
    logic           wb_valid;
    logic           wb_ready = 1'b0;
    logic [4:0]     wb_rd;
    logic [31:0]    wb_data;
    logic [1:0]     fsm_state;
    logic [CW-1:0]  occupancy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [36:0] got_q[$];
    logic [36:0] exp_q[$];
    int          start_q[$];

    rv16_mul_issue #(.QDEPTH(QDEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rd(req_rd), .req_a(req_a), .req_b(req_b),
        .flush(flush),
        .mul_start(mul_start), .mul_op_a(mul_op_a), .mul_op_b(mul_op_b),
        .mul_busy(mul_busy), .mul_done(mul_done), .mul_result(mul_result),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .fsm_state(fsm_state), .occupancy(occupancy)
    );

    // ---------------- clock / reset / watchdog ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- multiplier model ----------------
    // Samples start, done high 4 edges later, busy held one cycle past done.
    logic [2:0]  m_cnt;
    logic [31:0] m_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= '0;
            m_res <= '0;
        end else if (m_cnt == 3'd0) begin
            if (mul_start) begin
                m_cnt <= 3'd1;
                m_res <= mul_op_a * mul_op_b;
            end
        end else if (m_cnt == 3'd5) begin
            m_cnt <= 3'd0;
        end else begin
            m_cnt <= m_cnt + 3'd1;
        end
    end

    assign mul_busy   = (m_cnt != 3'd0);
    assign mul_done   = (m_cnt == 3'd4);
    assign mul_result = m_res;

    // ---------------- observation ----------------
    always @(posedge clk) begin
        if (rst_n && wb_valid && wb_ready) got_q.push_back({wb_rd, wb_data});
        if (rst_n && mul_start) start_q.push_back(cyc);
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] full;
        full = {32'd0, a} * {32'd0, b};
        return full[31:0];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_req(input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
        bit ok;
        ok = 1'b0;
        req_valid = 1'b1;
        req_rd = rd;
        req_a = a;
        req_b = b;
        for (int i = 0; i < 200; i++) begin
            if (req_ready) begin
                step(1);
                ok = 1'b1;
                break;
            end
            step(1);
        end
        req_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: req_ready stayed 0 for rd=%0d, required 1 within 200 cycles", rd);
        end
    endtask

    task automatic wait_wb(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (wb_valid) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        step(2);
        checks++;
        if ({mul_start, wb_valid, wb_rd, wb_data, mul_op_a, mul_op_b} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: start=%b wbv=%b rd=%0d data=%h a=%h b=%h, required all 0",
                     mul_start, wb_valid, wb_rd, wb_data, mul_op_a, mul_op_b);
        end
        checks++;
        if (occupancy !== '0) begin
            errors++;
            $display("FAIL reset_count: got %0d, required 0", occupancy);
        end
        #2 rst_n = 1'b1;
        step(1);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b, required 1", req_ready);
        end
    endtask

    task automatic test_single();
        logic [31:0] exp;
        exp = ref_mul(32'd3, 32'd5);
        wb_ready = 1'b1;
        req_valid = 1'b1;
        req_rd = 5'd7;
        req_a = 32'd3;
        req_b = 32'd5;
        step(1);
        req_valid = 1'b0;
        checks++;
        if (mul_start !== 1'b0) begin
            errors++;
            $display("FAIL single_start_e0: got %b, required 0", mul_start);
        end
        step(1);
        checks++;
        if (mul_start !== 1'b1 || mul_op_a !== 32'd3 || mul_op_b !== 32'd5) begin
            errors++;
            $display("FAIL single_issue_e1: start=%b a=%h b=%h, required 1/3/5", mul_start, mul_op_a, mul_op_b);
        end
        for (int e = 2; e <= 5; e++) begin
            step(1);
            checks++;
            if (mul_start !== 1'b0 || wb_valid !== 1'b0) begin
                errors++;
                $display("FAIL single_quiet_e%0d: start=%b wbv=%b, required 0/0", e, mul_start, wb_valid);
            end
        end
        step(1);
        checks++;
        if (wb_valid !== 1'b1 || wb_rd !== 5'd7 || wb_data !== exp) begin
            errors++;
            $display("FAIL single_wb_e6: wbv=%b rd=%0d data=%h, required 1/7/%h", wb_valid, wb_rd, wb_data, exp);
        end
        step(1);
        checks++;
        if (wb_valid !== 1'b0 || mul_op_a !== 32'd3) begin
            errors++;
            $display("FAIL single_done_e7: wbv=%b op_a=%h, required 0/3", wb_valid, mul_op_a);
        end
    endtask

    task automatic test_width();
        bit ok;
        step(3);
        wb_ready = 1'b1;
        push_req(5'd12, 32'h0001_0003, 32'h0002_0005);
        wait_wb(40, ok);
        checks++;
        if (!ok || wb_data !== 32'h000B_000F || wb_rd !== 5'd12) begin
            errors++;
            $display("FAIL width_product: valid=%b rd=%0d data=%h, required 1/12/000b000f", ok, wb_rd, wb_data);
        end
        step(1);
    endtask

    task automatic test_back_pressure();
        bit ok;
        logic [31:0] a1, b1, a2, b2;
        a1 = $urandom();
        b1 = $urandom();
        a2 = $urandom();
        b2 = $urandom();
        step(3);
        wb_ready = 1'b0;
        push_req(5'd9, a1, b1);
        push_req(5'd10, a2, b2);
        wait_wb(40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_wb_timeout: wb_valid=0, required 1 within 40 cycles");
        end
        start_q.delete();
        for (int i = 0; i < 10; i++) begin
            step(1);
            checks++;
            if (wb_valid !== 1'b1 || wb_rd !== 5'd9 || wb_data !== ref_mul(a1, b1)) begin
                errors++;
                $display("FAIL bp_hold_%0d: wbv=%b rd=%0d data=%h, required 1/9/%h",
                         i, wb_valid, wb_rd, wb_data, ref_mul(a1, b1));
            end
        end
        checks++;
        if (start_q.size() != 0) begin
            errors++;
            $display("FAIL bp_no_issue: %0d starts during hold, required 0", start_q.size());
        end
        wb_ready = 1'b1;
        step(1);
        checks++;
        if (wb_valid !== 1'b0 || mul_start !== 1'b1 || mul_op_a !== a2) begin
            errors++;
            $display("FAIL bp_release: wbv=%b start=%b op_a=%h, required 0/1/%h", wb_valid, mul_start, mul_op_a, a2);
        end
        wait_wb(40, ok);
        checks++;
        if (!ok || wb_rd !== 5'd10 || wb_data !== ref_mul(a2, b2)) begin
            errors++;
            $display("FAIL bp_second: valid=%b rd=%0d data=%h, required 1/10/%h", ok, wb_rd, wb_data, ref_mul(a2, b2));
        end
        step(1);
    endtask

    task automatic test_full_queue();
        logic [4:0]  rd;
        logic [31:0] a, b;
        step(3);
        wb_ready = 1'b1;
        got_q.delete();
        exp_q.delete();
        start_q.delete();
        for (int k = 0; k < 3; k++) begin
            rd = 5'(20 + k);
            a = $urandom();
            b = $urandom();
            push_req(rd, a, b);
            exp_q.push_back({rd, ref_mul(a, b)});
        end
        checks++;
        if (req_ready !== 1'b0 || occupancy !== CW'(2)) begin
            errors++;
            $display("FAIL full_ready: ready=%b count=%0d, required 0/2", req_ready, occupancy);
        end
        for (int i = 0; i < 100 && got_q.size() < 3; i++) step(1);
        checks++;
        if (got_q.size() != 3) begin
            errors++;
            $display("FAIL full_count: %0d writebacks, required 3", got_q.size());
        end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL full_order_%0d: got rd=%0d data=%h, required rd=%0d data=%h",
                         i, got_q[i][36:32], got_q[i][31:0], exp_q[i][36:32], exp_q[i][31:0]);
            end
        end
        checks++;
        if (start_q.size() != 3 || (start_q[1] - start_q[0]) != 7 || (start_q[2] - start_q[1]) != 7) begin
            errors++;
            $display("FAIL full_interval: %0d starts, gaps %0d/%0d, required 3 starts, gaps 7/7",
                     start_q.size(), start_q.size() > 1 ? start_q[1] - start_q[0] : -1,
                     start_q.size() > 2 ? start_q[2] - start_q[1] : -1);
        end
    endtask

    task automatic test_flush();
        bit ok;
        logic [31:0] a, b;
        step(3);
        wb_ready = 1'b1;
        got_q.delete();
        start_q.delete();
        push_req(5'd3, $urandom(), $urandom());
        push_req(5'd4, $urandom(), $urandom());
        step(1);
        flush = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: got %b, required 0 while flushing", req_ready);
        end
        step(1);
        flush = 1'b0;
        checks++;
        if (occupancy !== '0) begin
            errors++;
            $display("FAIL flush_count: got %0d, required 0", occupancy);
        end
        step(12);
        checks++;
        if (got_q.size() != 0 || start_q.size() != 1 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_discard: %0d writebacks, %0d starts, wbv=%b, required 0/1/0",
                     got_q.size(), start_q.size(), wb_valid);
        end
        a = $urandom();
        b = $urandom();
        push_req(5'd5, a, b);
        wait_wb(40, ok);
        checks++;
        if (!ok || wb_rd !== 5'd5 || wb_data !== ref_mul(a, b)) begin
            errors++;
            $display("FAIL flush_recover: valid=%b rd=%0d data=%h, required 1/5/%h", ok, wb_rd, wb_data, ref_mul(a, b));
        end
        step(1);
    endtask

    task automatic test_async_reset();
        bit ok;
        step(3);
        wb_ready = 1'b0;
        push_req(5'd11, $urandom(), $urandom());
        push_req(5'd12, $urandom(), $urandom());
        wait_wb(40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL areset_setup: wb_valid=0, required 1 before reset");
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (wb_valid !== 1'b0 || occupancy !== '0 || mul_start !== 1'b0 || wb_data !== '0) begin
            errors++;
            $display("FAIL areset_immediate: wbv=%b count=%0d start=%b data=%h, required 0/0/0/0",
                     wb_valid, occupancy, mul_start, wb_data);
        end
        #2 rst_n = 1'b1;
        step(1);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL areset_ready: got %b, required 1", req_ready);
        end
        wb_ready = 1'b1;
        got_q.delete();
        step(15);
        checks++;
        if (got_q.size() != 0) begin
            errors++;
            $display("FAIL areset_no_wb: %0d writebacks, required 0", got_q.size());
        end
    endtask

    task automatic test_random();
        int n_req;
        bit sent_all;
        n_req = 24;
        sent_all = 1'b0;
        step(3);
        got_q.delete();
        exp_q.delete();
        fork
            begin
                logic [4:0]  rd;
                logic [31:0] a, b;
                for (int i = 0; i < n_req; i++) begin
                    rd = 5'($urandom_range(0, 31));
                    a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom();
                    b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom();
                    step($urandom_range(0, 3));
                    push_req(rd, a, b);
                    exp_q.push_back({rd, ref_mul(a, b)});
                end
                sent_all = 1'b1;
            end
            begin
                for (int c = 0; c < 3000 && !(sent_all && got_q.size() >= exp_q.size()); c++) begin
                    wb_ready = ($urandom_range(0, 3) != 0);
                    step(1);
                end
                wb_ready = 1'b1;
            end
        join
        checks++;
        if (got_q.size() != n_req) begin
            errors++;
            $display("FAIL rand_count: %0d writebacks, required %0d", got_q.size(), n_req);
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rand_wb_%0d: got rd=%0d data=%h, required rd=%0d data=%h",
                         i, got_q[i][36:32], got_q[i][31:0], exp_q[i][36:32], exp_q[i][31:0]);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_width();
        test_back_pressure();
        test_full_queue();
        test_flush();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rv16_mul_issue.md
RV16_MUL_ISSUE -- requirements
Module: rv16_mul_issue

Interface
REQ-001 SHALL have parameter QDEPTH, default 2, request queue depth in entries (power of 2, >=2).
REQ-002 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  decode presents a multiply request.
REQ-005 SHALL have port req_ready  output  1  request accepted on the edge where req_valid && req_ready.
REQ-006 SHALL have port req_rd  input  5  destination register tag.
REQ-007 SHALL have ports req_a, req_b  input  32 each  operands.
REQ-008 SHALL have port flush  input  1  one-cycle pulse that kills queued and in-flight requests.
REQ-009 SHALL have ports mul_start  output  1, and mul_op_a, mul_op_b  output  32 each; these drive the multiplier.
REQ-010 SHALL have ports mul_busy  input  1, mul_done  input  1, and mul_result  input  32; these come from the multiplier.
REQ-011 SHALL have port wb_valid  output  1  writeback result available.
REQ-012 SHALL have port wb_ready  input  1  writeback accepts on the edge where wb_valid && wb_ready.
REQ-013 SHALL have ports wb_rd  output  5 and wb_data  output  32, carrying the writeback tag and product.

Function
REQ-014 SHALL hold a FIFO of QDEPTH entries {rd, a, b} with an occupancy count 0..QDEPTH; pointers wrap modulo QDEPTH.
REQ-015 SHALL drive req_ready = (count < QDEPTH) && !flush, combinationally.
REQ-016 SHALL allow push and pop on the same edge; count is then unchanged, with no full-queue bypass.
REQ-017 SHALL implement FSM states IDLE, WAIT, WB, DRAIN.
REQ-018 IDLE: if count!=0 && !mul_busy && !flush, SHALL register mul_start=1, mul_op_a/b=head a/b, in-flight rd=head rd, pop the head, and go to WAIT.
REQ-019 SHALL drive mul_start high for exactly one cycle per issue; mul_op_a/b SHALL hold their value until the next issue.
REQ-020 WAIT: SHALL sample mul_done only while mul_start is low; on mul_done it SHALL register wb_data=mul_result, wb_rd=in-flight rd, wb_valid=1, and go to WB.
REQ-021 WB: SHALL hold wb_valid, wb_rd and wb_data stable until wb_ready.
REQ-022 WB, on wb_ready: SHALL clear wb_valid, then apply REQ-018 in the same cycle if its condition holds (back-to-back issue), else go to IDLE.
REQ-023 Latency: a request accepted at edge E0 into an empty IDLE unit SHALL raise mul_start after E1 and raise wb_valid after E6, given a multiplier whose done is registered 4 edges after it samples start.
REQ-024 With wb_ready held high and a full queue, SHALL issue one multiply every 7 cycles.
REQ-025 flush SHALL set count=0 on that edge, and no push occurs that edge.
REQ-026 flush in WAIT, including the cycle mul_start is high, SHALL go to DRAIN.
REQ-027 DRAIN: SHALL wait for mul_done, discard mul_result, leave wb_* unchanged, and go to IDLE.
REQ-028 flush in WB SHALL clear wb_valid and go to IDLE, whatever wb_ready is.
REQ-029 flush in IDLE SHALL suppress the issue that edge.
REQ-030 SHALL pass operands through unmodified; product width and truncation are set by the multiplier (low 32 bits).

Reset
REQ-031 While rst_n is low, SHALL force state=IDLE, count=0, pointers=0, and mul_start=0, mul_op_a=0, mul_op_b=0, wb_valid=0, wb_rd=0, wb_data=0.
REQ-032 req_ready SHALL read 1 once rst_n is high and flush is low.
REQ-033 Reset mid-operation SHALL discard all queued and in-flight requests with no writeback.
REQ-034 Multiplier and issue unit SHALL share rst_n, so no stale mul_done is seen after reset.

Verification
REQ-035 Single op: rd=7, a=3, b=5 accepted at E0, wb_ready=1 -> mul_start high only in cycle E1-E2; wb_valid after E6 with wb_rd=7, wb_data=15.
REQ-036 Width: a=0x0001_0003, b=0x0002_0005 -> wb_data=0x000B_000F (low 32 bits).
REQ-037 Back-pressure: wb_ready=0 for 10 cycles after wb_valid -> wb_rd/wb_data stable; no new mul_start; handshake then clears wb_valid.
REQ-038 Full queue: push 3 requests while the first is in flight (QDEPTH=2) -> req_ready=0 with count=2; writebacks come in order with correct tags; issue interval 7 cycles.
REQ-039 Flush: flush in cycle E3 of a single op plus one queued op -> no wb_valid; mul_done discarded in DRAIN; a new request accepted afterwards completes normally.
REQ-040 Async reset: rst_n low in WB state -> wb_valid=0 immediately, count=0; after release, req_ready=1.
